// File: rtl/clock_monitor.sv
// Health monitor for a divided clock sampled as data in the clk_i domain.
// Measures rise-to-rise period and high time, flags bad periods and a stuck input, and reports lock.
module clock_monitor #(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EXP_PERIOD  = 3,
  parameter int TOL         = 0,
  parameter int LOCK_COUNT  = 4,
  parameter int TIMEOUT     = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             mon_clk_i,
  input  logic             clear_err_i,
  output logic             valid_o,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_o,
  output logic             locked_o,
  output logic             err_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic             stuck_o
);

  typedef enum logic {
    ACQUIRE = 1'b0,
    MEASURE = 1'b1
  } state_t;

  localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0]  ONE_C     = CNT_W'(1);
  localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W:0]    EXP_C     = (CNT_W + 1)'(EXP_PERIOD);
  localparam logic [CNT_W:0]    TOL_C     = (CNT_W + 1)'(TOL);
  localparam logic [GOOD_W-1:0] LOCK_C    = GOOD_W'(LOCK_COUNT);

  state_t             state_reg, state_next;
  logic [SYNC_STAGES-1:0] sync_reg;
  logic               edge_reg;
  logic [CNT_W-1:0]   pcnt_reg, pcnt_next;
  logic [CNT_W-1:0]   hcnt_reg, hcnt_next;
  logic [CNT_W-1:0]   period_reg, period_next;
  logic [CNT_W-1:0]   high_reg, high_next;
  logic               valid_reg, valid_next;
  logic               locked_reg, locked_next;
  logic               err_reg, err_next;
  logic [CNT_W-1:0]   err_cnt_reg, err_cnt_next;
  logic               stuck_reg, stuck_next;
  logic [GOOD_W-1:0]  good_reg, good_next;

  logic               sync_s;
  logic               rise;
  logic [CNT_W:0]     period_ext;
  logic [CNT_W:0]     period_dev;
  logic               period_good;
  logic [GOOD_W-1:0]  good_inc;
  logic               err_event;

  assign sync_s = sync_reg[SYNC_STAGES-1];
  assign rise   = sync_s & ~edge_reg;

  // Deviation is taken one bit wider than the counter so it never wraps.
  assign period_ext  = {1'b0, pcnt_reg};
  assign period_dev  = (period_ext >= EXP_C) ? (period_ext - EXP_C) : (EXP_C - period_ext);
  assign period_good = (period_dev <= TOL_C);
  assign good_inc    = (good_reg == LOCK_C) ? good_reg : (good_reg + 1'b1);

  always_comb begin
    state_next   = state_reg;
    pcnt_next    = pcnt_reg;
    hcnt_next    = hcnt_reg;
    period_next  = period_reg;
    high_next    = high_reg;
    valid_next   = 1'b0;
    locked_next  = locked_reg;
    err_next     = err_reg;
    err_cnt_next = err_cnt_reg;
    stuck_next   = stuck_reg;
    good_next    = good_reg;
    err_event    = 1'b0;

    case (state_reg)
      ACQUIRE: begin
        // First edge only establishes the reference; the partial period is discarded.
        if (rise) begin
          state_next = MEASURE;
          pcnt_next  = ONE_C;
          hcnt_next  = ONE_C;
          stuck_next = 1'b0;
        end
      end
      MEASURE: begin
        if (rise) begin
          period_next = pcnt_reg;
          high_next   = hcnt_reg;
          valid_next  = 1'b1;
          pcnt_next   = ONE_C;
          hcnt_next   = ONE_C;
          if (period_good) begin
            good_next   = good_inc;
            locked_next = (good_inc == LOCK_C);
          end else begin
            good_next   = '0;
            locked_next = 1'b0;
            err_event   = 1'b1;
          end
        end else if (pcnt_reg == TIMEOUT_C) begin
          stuck_next  = 1'b1;
          locked_next = 1'b0;
          good_next   = '0;
          err_event   = 1'b1;
          state_next  = ACQUIRE;
        end else begin
          pcnt_next = pcnt_reg + ONE_C;
          if (sync_s) begin
            hcnt_next = hcnt_reg + ONE_C;
          end
        end
      end
    endcase

    // A clear in the same cycle as a new error leaves exactly that one error recorded.
    if (clear_err_i) begin
      err_next     = err_event;
      err_cnt_next = err_event ? ONE_C : '0;
    end else if (err_event) begin
      err_next     = 1'b1;
      err_cnt_next = (err_cnt_reg == '1) ? err_cnt_reg : (err_cnt_reg + ONE_C);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_reg   <= ACQUIRE;
      sync_reg    <= '0;
      edge_reg    <= 1'b0;
      pcnt_reg    <= '0;
      hcnt_reg    <= '0;
      period_reg  <= '0;
      high_reg    <= '0;
      valid_reg   <= 1'b0;
      locked_reg  <= 1'b0;
      err_reg     <= 1'b0;
      err_cnt_reg <= '0;
      stuck_reg   <= 1'b0;
      good_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      sync_reg    <= {sync_reg[SYNC_STAGES-2:0], mon_clk_i};
      edge_reg    <= sync_s;
      pcnt_reg    <= pcnt_next;
      hcnt_reg    <= hcnt_next;
      period_reg  <= period_next;
      high_reg    <= high_next;
      valid_reg   <= valid_next;
      locked_reg  <= locked_next;
      err_reg     <= err_next;
      err_cnt_reg <= err_cnt_next;
      stuck_reg   <= stuck_next;
      good_reg    <= good_next;
    end
  end

  assign valid_o   = valid_reg;
  assign period_o  = period_reg;
  assign high_o    = high_reg;
  assign locked_o  = locked_reg;
  assign err_o     = err_reg;
  assign err_cnt_o = err_cnt_reg;
  assign stuck_o   = stuck_reg;

endmodule

// File: tb/tb_clock_monitor.sv
// Bench for clock_monitor: two instances (TOL=0 and TOL=1) driven by directed and random
// mon_clk_i waveforms, checked against a timestamp-based model of the input sample stream.
module tb_clock_monitor;

  localparam int SS   = 2;
  localparam int EXP  = 3;
  localparam int LOCK = 4;
  localparam int TMO  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_i, mon_clk_i, clear_err_i;
  logic       valid_a, locked_a, err_a, stuck_a;
  logic [7:0] period_a, high_a, err_cnt_a;
  logic       valid_b, locked_b, err_b, stuck_b;
  logic [7:0] period_b, high_b, err_cnt_b;

  clock_monitor #(.CNT_W(8), .SYNC_STAGES(SS), .EXP_PERIOD(EXP), .TOL(0),
                  .LOCK_COUNT(LOCK), .TIMEOUT(TMO)) dut_a (
    .clk_i(clk), .reset_i(reset_i), .mon_clk_i(mon_clk_i), .clear_err_i(clear_err_i),
    .valid_o(valid_a), .period_o(period_a), .high_o(high_a), .locked_o(locked_a),
    .err_o(err_a), .err_cnt_o(err_cnt_a), .stuck_o(stuck_a));

  clock_monitor #(.CNT_W(8), .SYNC_STAGES(SS), .EXP_PERIOD(EXP), .TOL(1),
                  .LOCK_COUNT(LOCK), .TIMEOUT(TMO)) dut_b (
    .clk_i(clk), .reset_i(reset_i), .mon_clk_i(mon_clk_i), .clear_err_i(clear_err_i),
    .valid_o(valid_b), .period_o(period_b), .high_o(high_b), .locked_o(locked_b),
    .err_o(err_b), .err_cnt_o(err_cnt_b), .stuck_o(stuck_b));

  int total = 0;
  int bad   = 0;
  int cyc_n = 0;

  // Model: samples since reset with timestamps of the reference rising edge.
  bit   hist[$];
  int   n_smp;
  int   tol_m[2] = '{0, 1};
  bit   have_ref[2];
  int   ref_m[2];
  int   good_run[2];
  bit   e_valid[2], e_locked[2], e_err[2], e_stuck[2];
  logic [7:0] e_period[2], e_high[2], e_cnt[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc_n, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      have_ref[i] = 0; ref_m[i] = 0; good_run[i] = 0;
      e_valid[i] = 0; e_locked[i] = 0; e_err[i] = 0; e_stuck[i] = 0;
      e_period[i] = '0; e_high[i] = '0; e_cnt[i] = '0;
    end
    hist.delete();
    n_smp = 0;
  endfunction

  // Interprets sample m of the stream for instance i; returns 1 on an error event.
  function automatic bit model_step(input int i, input int m);
    bit prev = (m > 0) ? hist[m-1] : 1'b0;
    bit is_rise = hist[m] && !prev;
    bit ev = 0;
    int per, hi, dev;
    if (is_rise) begin
      if (have_ref[i]) begin
        per = m - ref_m[i];
        hi = 0;
        while ((ref_m[i] + hi < m) && hist[ref_m[i] + hi]) hi++;
        e_period[i] = 8'(per);
        e_high[i]   = 8'(hi);
        e_valid[i]  = 1;
        dev = (per > EXP) ? (per - EXP) : (EXP - per);
        if (dev <= tol_m[i]) begin
          good_run[i]++;
          e_locked[i] = (good_run[i] >= LOCK);
        end else begin
          good_run[i] = 0;
          e_locked[i] = 0;
          ev = 1;
        end
      end else begin
        have_ref[i] = 1;
        e_stuck[i]  = 0;
      end
      ref_m[i] = m;
    end else if (have_ref[i] && (m - ref_m[i] == TMO)) begin
      e_stuck[i]  = 1;
      e_locked[i] = 0;
      good_run[i] = 0;
      have_ref[i] = 0;
      ev = 1;
    end
    return ev;
  endfunction

  function automatic void model_edge(input bit mon, input bit clr, input bit rst);
    bit ev;
    if (rst) begin
      model_reset();
    end else begin
      hist.push_back(mon);
      for (int i = 0; i < 2; i++) begin
        e_valid[i] = 0;
        ev = (n_smp >= SS) ? model_step(i, n_smp - SS) : 1'b0;
        if (clr) begin
          e_err[i] = ev;
          e_cnt[i] = ev ? 8'd1 : 8'd0;
        end else if (ev) begin
          e_err[i] = 1;
          if (e_cnt[i] != 8'hFF) e_cnt[i] = e_cnt[i] + 8'd1;
        end
      end
      n_smp++;
    end
  endfunction

  task automatic check_all();
    chk("valid_a", 32'(valid_a), 32'(e_valid[0]));
    chk("period_a", 32'(period_a), 32'(e_period[0]));
    chk("high_a", 32'(high_a), 32'(e_high[0]));
    chk("locked_a", 32'(locked_a), 32'(e_locked[0]));
    chk("err_a", 32'(err_a), 32'(e_err[0]));
    chk("err_cnt_a", 32'(err_cnt_a), 32'(e_cnt[0]));
    chk("stuck_a", 32'(stuck_a), 32'(e_stuck[0]));
    chk("valid_b", 32'(valid_b), 32'(e_valid[1]));
    chk("period_b", 32'(period_b), 32'(e_period[1]));
    chk("high_b", 32'(high_b), 32'(e_high[1]));
    chk("locked_b", 32'(locked_b), 32'(e_locked[1]));
    chk("err_b", 32'(err_b), 32'(e_err[1]));
    chk("err_cnt_b", 32'(err_cnt_b), 32'(e_cnt[1]));
    chk("stuck_b", 32'(stuck_b), 32'(e_stuck[1]));
  endtask

  task automatic cyc(input bit mon, input bit clr, input bit rst);
    mon_clk_i   = mon;
    clear_err_i = clr;
    reset_i     = rst;
    @(posedge clk);
    model_edge(mon, clr, rst);
    #1;
    cyc_n++;
    check_all();
  endtask

  // reps periods of length p with the first h samples high.
  task automatic pat(input int p, input int h, input int reps);
    for (int r = 0; r < reps; r++)
      for (int j = 0; j < p; j++) cyc(j < h, 1'b0, 1'b0);
  endtask

  task automatic chk_zero_a(input string tag);
    chk({tag, "_valid"}, 32'(valid_a), 32'd0);
    chk({tag, "_period"}, 32'(period_a), 32'd0);
    chk({tag, "_high"}, 32'(high_a), 32'd0);
    chk({tag, "_locked"}, 32'(locked_a), 32'd0);
    chk({tag, "_err"}, 32'(err_a), 32'd0);
    chk({tag, "_errcnt"}, 32'(err_cnt_a), 32'd0);
    chk({tag, "_stuck"}, 32'(stuck_a), 32'd0);
  endtask

  initial begin
    int r, p, h, g;
    model_reset();
    reset_i = 1'b1; mon_clk_i = 1'b0; clear_err_i = 1'b0;
    cyc(0, 0, 1);
    cyc(1, 0, 1);
    chk_zero_a("reset");

    // Nominal 1,1,0 stream locks on the fourth measured period.
    pat(3, 2, 8);
    chk("nom_period", 32'(period_a), 32'd3);
    chk("nom_high", 32'(high_a), 32'd2);
    chk("nom_locked", 32'(locked_a), 32'd1);
    chk("nom_err", 32'(err_a), 32'd0);

    // One stretched period breaks lock; four good periods restore it.
    pat(4, 2, 1);
    pat(3, 2, 1);
    chk("stretch_period", 32'(period_a), 32'd4);
    chk("stretch_err", 32'(err_a), 32'd1);
    chk("stretch_cnt", 32'(err_cnt_a), 32'd1);
    chk("stretch_locked", 32'(locked_a), 32'd0);
    chk("stretch_tol1_err", 32'(err_b), 32'd0);
    pat(3, 2, 3);
    chk("relock_3", 32'(locked_a), 32'd0);
    pat(3, 2, 1);
    chk("relock_4", 32'(locked_a), 32'd1);
    pat(3, 2, 1);

    // Stuck low input.
    pat(1, 0, 20);
    chk("stuck_set", 32'(stuck_a), 32'd1);
    chk("stuck_cnt", 32'(err_cnt_a), 32'd2);
    chk("stuck_locked", 32'(locked_a), 32'd0);
    pat(3, 2, 1);
    chk("stuck_clear", 32'(stuck_a), 32'd0);
    chk("stuck_novalid", 32'(valid_a), 32'd0);
    pat(3, 2, 1);
    chk("post_stuck_valid", 32'(valid_a), 32'd1);
    chk("post_stuck_period", 32'(period_a), 32'd3);

    // Tolerance: periods 3,2,3,4,5 after a fresh reset.
    cyc(0, 0, 1);
    pat(3, 2, 1); pat(2, 1, 1); pat(3, 2, 1); pat(4, 2, 1); pat(5, 2, 1); pat(3, 2, 1);
    chk("tol0_cnt", 32'(err_cnt_a), 32'd3);
    chk("tol1_cnt", 32'(err_cnt_b), 32'd1);

    // Clear on its own, then clear coinciding with a bad period.
    cyc(1, 0, 0); cyc(1, 1, 0); cyc(0, 0, 0);
    chk("clr_err_a", 32'(err_a), 32'd0);
    chk("clr_cnt_a", 32'(err_cnt_a), 32'd0);
    chk("clr_cnt_b", 32'(err_cnt_b), 32'd0);
    pat(5, 2, 1);
    cyc(1, 0, 0); cyc(1, 0, 0); cyc(0, 1, 0);
    chk("clr_same_err_a", 32'(err_a), 32'd1);
    chk("clr_same_cnt_a", 32'(err_cnt_a), 32'd1);
    chk("clr_same_cnt_b", 32'(err_cnt_b), 32'd1);

    // Reset mid-period while locked.
    pat(3, 2, 5);
    chk("pre_rst_locked", 32'(locked_a), 32'd1);
    cyc(1, 0, 0);
    cyc(1, 0, 1);
    chk_zero_a("midrst");
    pat(3, 2, 1);
    chk("midrst_ref_novalid", 32'(valid_a), 32'd0);
    pat(3, 2, 1);
    chk("midrst_first_valid", 32'(valid_a), 32'd1);

    // Random periods, gaps, clears and occasional resets.
    for (int t = 0; t < 80; t++) begin
      r = $urandom_range(0, 19);
      if (r == 0) begin
        g = $urandom_range(18, 22);
        for (int j = 0; j < g; j++) cyc(1'b0, ($urandom_range(0, 15) == 0), 1'b0);
      end else if (r == 1) begin
        cyc(1'b0, 1'b0, 1'b1);
      end else begin
        p = $urandom_range(2, 6);
        h = $urandom_range(1, p - 1);
        for (int j = 0; j < p; j++) cyc(j < h, ($urandom_range(0, 15) == 0), 1'b0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
